// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder slice.
package serial_adder_pkg;

    localparam int unsigned SA_DEFAULT_WIDTH = 32'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/adder_1bit.sv
// Existing 1-bit full adder cell; purely combinational.
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a single
// full-adder cell, LSB first, with a registered carry between cycles.
module serial_adder_nbit
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = (WIDTH > 32'd1) ? $clog2(WIDTH) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    sa_state_t        state_r, state_s;
    logic [WIDTH-1:0] opa_r, opa_s;
    logic [WIDTH-1:0] opb_r, opb_s;
    logic [WIDTH-1:0] res_r, res_s;
    logic             carry_r, carry_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic [WIDTH-1:0] sum_r, sum_s;
    logic             carry_out_r, carry_out_s;
    logic             overflow_r, overflow_s;
    logic             cell_sum_s, cell_carry_s;

    adder_1bit u_cell (
        .a         (opa_r[0]),
        .b         (opb_r[0]),
        .carry_in  (carry_r),
        .sum       (cell_sum_s),
        .carry_out (cell_carry_s)
    );

    // Next-state, datapath and registered-output values for every state.
    always_comb begin
        state_s     = state_r;
        opa_s       = opa_r;
        opb_s       = opb_r;
        res_s       = res_r;
        carry_s     = carry_r;
        cnt_s       = cnt_r;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        sum_s       = sum_r;
        carry_out_s = carry_out_r;
        overflow_s  = overflow_r;
        case (state_r)
            IDLE, DONE: begin
                // DONE accepts a new start exactly like IDLE so additions can run back to back.
                if (start) begin
                    opa_s   = a;
                    opb_s   = b;
                    carry_s = carry_in;
                    cnt_s   = '0;
                    busy_s  = 1'b1;
                    state_s = ADD;
                end else begin
                    state_s = IDLE;
                end
            end
            ADD: begin
                opa_s   = {1'b0, opa_r[WIDTH-1:1]};
                opb_s   = {1'b0, opb_r[WIDTH-1:1]};
                res_s   = {cell_sum_s, res_r[WIDTH-1:1]};
                carry_s = cell_carry_s;
                cnt_s   = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    // carry_r here is the carry into the MSB position.
                    sum_s       = {cell_sum_s, res_r[WIDTH-1:1]};
                    carry_out_s = cell_carry_s;
                    overflow_s  = carry_r ^ cell_carry_s;
                    done_s      = 1'b1;
                    state_s     = DONE;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            opa_r       <= '0;
            opb_r       <= '0;
            res_r       <= '0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            sum_r       <= '0;
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            opa_r       <= opa_s;
            opb_r       <= opb_s;
            res_r       <= res_s;
            carry_r     <= carry_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            sum_r       <= sum_s;
            carry_out_r <= carry_out_s;
            overflow_r  <= overflow_s;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign sum       = sum_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Scoreboard bench for serial_adder_nbit: expected results are queued at
// stimulus time and compared by an independent monitor on each done pulse.
module tb_serial_adder_nbit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t exp_q[$];
    res_t last_exp;
    int   checks = 0;
    int   errors = 0;

    serial_adder_nbit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: plain integer addition; signed overflow from operand/result signs.
    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] full;
        res_t       r;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=1 expected no pending result at %0t", $time);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("sum", {24'd0, sum}, {24'd0, e.s});
                check("carry_out", {31'd0, carry_out}, {31'd0, e.c});
                check("overflow", {31'd0, overflow}, {31'd0, e.v});
                last_exp = e;
            end
        end
    end

    // Called at a negedge: present a request, record its expected result,
    // then scramble the operand inputs once the start edge has passed.
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input bit hold);
        a        = x;
        b        = y;
        carry_in = ci;
        start    = 1'b1;
        exp_q.push_back(model(x, y, ci));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        carry_in = 1'($urandom);
        @(negedge clk);
    endtask

    // Expect W busy cycles then a done cycle; optionally pulse an ignored start.
    task automatic run_busy(input bit inject);
        for (int i = 0; i < W; i++) begin
            check("busy_high", {31'd0, busy}, 32'd1);
            check("done_low", {31'd0, done}, 32'd0);
            if (inject && i == 2) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else if (inject && i == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_end", {31'd0, busy}, 32'd0);
        check("done_pulse", {31'd0, done}, 32'd1);
    endtask

    // One cycle after done: pulse over, results held.
    task automatic tail();
        @(negedge clk);
        check("done_single", {31'd0, done}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("sum_hold", {24'd0, sum}, {24'd0, last_exp.s});
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        carry_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, carry_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'h5A, 8'h3C, 1'b0, 1'b0); run_busy(1'b0); tail();
        issue(8'hFF, 8'h01, 1'b0, 1'b0); run_busy(1'b0); tail();
        issue(8'h80, 8'h80, 1'b0, 1'b0); run_busy(1'b0); tail();
        issue(8'hFF, 8'h00, 1'b1, 1'b0); run_busy(1'b0); tail();

        // start during ADD is ignored
        issue(8'h10, 8'h20, 1'b0, 1'b0); run_busy(1'b1); tail();
        repeat (2) @(negedge clk);
        check("sum_hold_30", {24'd0, sum}, 32'h30);

        // back to back: start held through DONE
        issue(8'h7F, 8'h01, 1'b0, 1'b1); run_busy(1'b0);
        issue(8'h33, 8'h44, 1'b1, 1'b0); run_busy(1'b0); tail();

        // reset in the fourth ADD cycle discards the addition
        issue(8'hC3, 8'h5D, 1'b1, 1'b0);
        repeat (3) begin
            check("busy_pre_rst", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_sum", {24'd0, sum}, 32'd0);
        check("mid_rst_cout", {31'd0, carry_out}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        repeat (W + 3) begin
            @(negedge clk);
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end

        // randomized additions with random idle gaps
        for (int n = 0; n < 25; n++) begin
            x = W'($urandom);
            y = W'($urandom);
            issue(x, y, 1'($urandom), 1'b0);
            run_busy(1'b0);
            tail();
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Bit-serial N-bit adder controller; the stage directly around the team's 1-bit full adder cell.
- Latches two WIDTH-bit operands and a carry-in on a start request.
- Feeds one bit pair per clock, LSB first, into a single full-adder cell and registers the carry between cycles.
- Shifts the sum bits back into a result register and reports the sum, carry-out and signed overflow with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- start  input  1  request to begin an addition; sampled each rising edge.
- a  input  WIDTH  operand A; sampled only on the edge that accepts start.
- b  input  WIDTH  operand B; sampled only on the edge that accepts start.
- carry_in  input  1  initial carry; sampled with a and b.
- busy  output  1  high while a serial addition is in progress.
- done  output  1  one-cycle pulse: result outputs have just been updated.
- sum  output  WIDTH  registered result; holds until the next completion.
- carry_out  output  1  final carry out of the MSB; holds with sum.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB); holds with sum.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; busy, done, sum, carry_out and overflow all 0.
  - Internal operand shift registers, carry flop and bit counter all 0.
- States:
  - IDLE: busy=0, done=0. start=1 → load opa=a, opb=b, carry flop=carry_in, cnt=0; next state ADD.
  - ADD: busy=1.
    - Each edge: the adder cell sees opa[0], opb[0] and the carry flop.
    - Its sum bit is shifted into the MSB of the internal result shift register; opa and opb shift right by 1.
    - Carry flop takes the cell's carry-out; cnt increments.
    - On the edge where cnt==WIDTH-1: load sum from the completed shift value, carry_out from the cell carry, overflow = (carry into MSB) XOR (cell carry); next state DONE.
  - DONE: busy=0, done=1 for exactly this one cycle.
    - start=1 here is accepted exactly as in IDLE (back-to-back; next state ADD).
    - Otherwise next state IDLE.
- Latency:
  - Start accepted at edge E0.
  - busy is high for WIDTH cycles after E0.
  - Results update and done rises after edge E_WIDTH; throughput is one addition per WIDTH+1 cycles.
- start while in ADD: ignored. Operands, counter and carry are unaffected, and no queueing.
- Operand changes after acceptance: no effect, since operands are latched.
- Output holding: sum, carry_out and overflow change only on the completion edge. They are never partially updated and are not cleared on a new start.
- Carry into MSB: the carry flop value at the final ADD cycle (cnt==WIDTH-1).
- Counter: width $clog2(WIDTH); no wrap occurs because cnt resets on acceptance.
- Reset mid-operation: rst wins over all other inputs on the same edge.
  - All outputs and state return to reset values on that edge.
  - The in-flight addition is discarded and no done pulse is issued.
- No X propagation: all flops are reset; the next-state logic has a default branch to IDLE.

Decomposition:
- Shared package serial_adder_pkg:
  - typedef enum logic [1:0] {IDLE, ADD, DONE} sa_state_t.
  - Constant for the default width.
- One sub-module instance: the existing 1-bit full adder cell adder_1bit.
  - Inputs: a, b, carry_in. Outputs: sum, carry_out.
  - Combinational; driven from the LSBs of the operand shift registers and the carry flop.
- All other logic (FSM, counter, shift registers, output registers) lives in serial_adder_nbit.

Test Plan:
- WIDTH=8; a=0x5A, b=0x3C, carry_in=0, start for 1 cycle:
  - busy high for 8 cycles; done pulse 8 cycles after the start edge.
  - sum=0x96, carry_out=0, overflow=1.
- a=0xFF, b=0x01, carry_in=0 → sum=0x00, carry_out=1, overflow=0.
- a=0x80, b=0x80, carry_in=0 → sum=0x00, carry_out=1, overflow=1.
- a=0xFF, b=0x00, carry_in=1 → sum=0x00, carry_out=1, overflow=0.
- Start 0x10+0x20, then pulse start with a=0xFF, b=0xFF at cycle 3 of ADD:
  - Second request ignored; result sum=0x30, carry_out=0, overflow=0.
  - Single done pulse; sum holds 0x30 afterwards.
- Back-to-back and reset:
  - start held high through DONE → second addition begins with no IDLE cycle.
  - rst asserted at cycle 4 of an ADD → next cycle busy=0, done=0, sum=0, carry_out=0, overflow=0; no done pulse ever follows.
